// File: rtl/adder_seq_ctrl_if.sv
// Handshake/operand/result bundle for adder_seq_ctrl.
// Optional ovf signal present only with ADDER_SEQ_OVF_EN defined.
interface adder_seq_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef ADDER_SEQ_OVF_EN
   logic             ovf;
`endif

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
`ifdef ADDER_SEQ_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
`ifdef ADDER_SEQ_OVF_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/adder_seq_ctrl.sv
// Sequential adder: one SLICE-bit propagate/generate slice reused over WIDTH/SLICE RUN cycles.
// Define ADDER_SEQ_OVF_EN to add the signed-overflow output (bus.ovf).
module adder_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int SLICE = 4
) (
   input logic            clk,
   input logic            rst,
   adder_seq_ctrl_if.slave bus
);
   localparam int NSLICES = WIDTH / SLICE;
   localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic             carry_q, cout_q;
   logic [IDX_W-1:0] idx_q;
   logic             accept, last;

   logic [SLICE-1:0] a_sl, b_sl, p_sl, g_sl, s_sl;
   logic [SLICE:0]   c_chain;

   assign accept = bus.start && (state != RUN);
   assign last   = (idx_q == IDX_W'(NSLICES - 1));

   // Shared slice: ripple through SLICE bits starting from the running carry.
   always_comb begin
      a_sl       = a_q[idx_q*SLICE +: SLICE];
      b_sl       = b_q[idx_q*SLICE +: SLICE];
      p_sl       = a_sl ^ b_sl;
      g_sl       = a_sl & b_sl;
      s_sl       = '0;
      c_chain    = '0;
      c_chain[0] = carry_q;
      for (int unsigned i = 0; i < SLICE; i++) begin
         s_sl[i]       = p_sl[i] ^ c_chain[i];
         c_chain[i+1]  = g_sl[i] | (p_sl[i] & c_chain[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (bus.start) state_next = RUN;
         RUN:     if (last)      state_next = DONE;
         DONE:    state_next = bus.start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else if (accept) begin
         a_q     <= bus.a;
         b_q     <= bus.b;
         carry_q <= bus.cin;
         idx_q   <= '0;
      end else if (state == RUN) begin
         sum_q[idx_q*SLICE +: SLICE] <= s_sl;
         carry_q <= c_chain[SLICE];
         idx_q   <= last ? '0 : idx_q + 1'b1;
         if (last) cout_q <= c_chain[SLICE];
      end
   end

`ifdef ADDER_SEQ_OVF_EN
   logic ovf_q;

   // Top slice's chain holds both carry into and out of bit WIDTH-1.
   always_ff @(posedge clk) begin
      if (rst)                        ovf_q <= 1'b0;
      else if (state == RUN && last)  ovf_q <= c_chain[SLICE-1] ^ c_chain[SLICE];
   end

   assign bus.ovf = ovf_q;
`endif

   assign bus.busy = (state == RUN);
   assign bus.done = (state == DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed + random checks of adder_seq_ctrl (WIDTH=32, SLICE=4) against an arithmetic model.
// Define ADDER_SEQ_OVF_EN to also check the overflow output.
module tb_adder_seq_ctrl;
   localparam int W  = 32;
   localparam int NS = 8;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   logic [W-1:0] exp_sum;
   logic         exp_cout, exp_ovf;
   logic [W-1:0] ra, rb;
   logic         rc;
   int           dcount;

   always #5 clk = ~clk;

   adder_seq_ctrl_if #(.WIDTH(W)) bus ();

   adder_seq_ctrl #(.WIDTH(W), .SLICE(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference: plain unsigned addition; signed overflow from operand/result signs.
   task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      logic [W:0] full;
      full     = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      exp_sum  = full[W-1:0];
      exp_cout = full[W];
      exp_ovf  = (x[W-1] == y[W-1]) && (exp_sum[W-1] != x[W-1]);
   endtask

   task automatic wait_done(input string tag, input int pre);
      int  bcount;
      logic seen;
      bcount = pre;
      seen   = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         if (bus.busy) bcount++;
         @(negedge clk);
      end
      check({tag, " done_seen"}, W'(seen), W'(1));
      check({tag, " busy_cycles"}, W'(bcount), W'(NS));
      check({tag, " sum"}, bus.sum, exp_sum);
      check({tag, " cout"}, W'(bus.cout), W'(exp_cout));
`ifdef ADDER_SEQ_OVF_EN
      check({tag, " ovf"}, W'(bus.ovf), W'(exp_ovf));
`endif
   endtask

   task automatic finish_pulse(input string tag);
      @(negedge clk);
      check({tag, " done_one_cycle"}, W'(bus.done), W'(0));
      check({tag, " sum_held"}, bus.sum, exp_sum);
   endtask

   task automatic run_add(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c);
      model(x, y, c);
      bus.start = 1'b1;
      bus.a     = x;
      bus.b     = y;
      bus.cin   = c;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = $urandom();
      bus.b     = $urandom();
      wait_done(tag, 0);
      finish_pulse(tag);
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      repeat (3) @(negedge clk);
      check("reset busy", W'(bus.busy), W'(0));
      check("reset done", W'(bus.done), W'(0));
      check("reset sum", bus.sum, '0);
      check("reset cout", W'(bus.cout), W'(0));
`ifdef ADDER_SEQ_OVF_EN
      check("reset ovf", W'(bus.ovf), W'(0));
`endif
      rst = 1'b0;
      @(negedge clk);

      run_add("basic", 32'h0000_0001, 32'h0000_0002, 1'b0);
      run_add("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      run_add("sovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      run_add("negovf", 32'h8000_0000, 32'h8000_0000, 1'b1);

      repeat (3) @(negedge clk);
      check("idle hold sum", bus.sum, exp_sum);
      check("idle hold cout", W'(bus.cout), W'(exp_cout));

      for (int i = 0; i < 24; i++) begin
         ra = $urandom();
         rb = $urandom();
         rc = 1'($urandom_range(0, 1));
         run_add($sformatf("rand%0d", i), ra, rb, rc);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Second start mid-RUN must be ignored.
      model(32'h1234_5678, 32'h0FED_CBA9, 1'b0);
      bus.start = 1'b1;
      bus.a     = 32'h1234_5678;
      bus.b     = 32'h0FED_CBA9;
      bus.cin   = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 32'hFFFF_FFFF;
      bus.b     = 32'hFFFF_FFFF;
      bus.cin   = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("midstart", 3);
      dcount = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.done) dcount++;
      end
      check("midstart extra_done", W'(dcount), W'(0));

      // Back-to-back: start held while DONE.
      run_add("b2b_first", 32'hA5A5_0F0F, 32'h1111_2222, 1'b1);
      model(32'hCAFE_0000, 32'h0000_BEEF, 1'b0);
      bus.start = 1'b1;
      bus.a     = 32'hCAFE_0000;
      bus.b     = 32'h0000_BEEF;
      bus.cin   = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("b2b_pre", 0);
      check("b2b done_sum", bus.sum, 32'hCAFE_BEEF);
      bus.start = 1'b1;
      bus.a     = 32'd5;
      bus.b     = 32'd6;
      bus.cin   = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b sum_held_after_accept", bus.sum, 32'hCAFE_BEEF);
      check("b2b busy_after_accept", W'(bus.busy), W'(1));
      model(32'd5, 32'd6, 1'b0);
      wait_done("b2b", 0);
      check("b2b sum_B", bus.sum, 32'h0000_000B);
      finish_pulse("b2b");

      // Reset while slice 3 is being processed.
      model(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      run_add("pre_rst", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      bus.start = 1'b1;
      bus.a     = 32'h7777_7777;
      bus.b     = 32'h1111_1111;
      bus.cin   = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst slices_written", bus.sum[11:0], 32'h0000_0889);
      rst = 1'b1;
      @(negedge clk);
      check("rst busy", W'(bus.busy), W'(0));
      check("rst done", W'(bus.done), W'(0));
      check("rst sum", bus.sum, '0);
      check("rst cout", W'(bus.cout), W'(0));
      rst = 1'b0;
      dcount = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) dcount++;
      end
      check("rst no_done", W'(dcount), W'(0));

      run_add("post_rst", 32'h8000_0001, 32'h8000_0001, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/adder_seq_ctrl.md
ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter SLICE, default 4, meaning bits added per RUN cycle by the shared propagate/generate slice.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset; synchronous, active-high.
REQ-005 The block SHALL have port start, input, 1, meaning request an addition; sampled on the rising edge.
REQ-006 The block SHALL have ports a and b, input, WIDTH, meaning operands, sampled only on the edge that accepts start.
REQ-007 The block SHALL have port cin, input, 1, meaning carry-in, sampled with a and b.
REQ-008 The block SHALL have port busy, output, 1, meaning the FSM is in RUN.
REQ-009 The block SHALL have port done, output, 1, meaning a one-cycle result-valid pulse.
REQ-010 The block SHALL have port sum, output, WIDTH, meaning registered result.
REQ-011 The block SHALL have port cout, output, 1, meaning registered carry-out of bit WIDTH-1.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE; busy = (state==RUN), done = (state==DONE).
REQ-013 In IDLE or DONE, start=1 SHALL latch a, b and cin, clear the slice index to 0, and enter RUN.
REQ-014 In IDLE with start=0, the FSM SHALL stay in IDLE; in DONE with start=0, it SHALL return to IDLE.
REQ-015 start asserted while in RUN SHALL be ignored; latched operands SHALL NOT change.
REQ-016 Each RUN cycle SHALL process slice k (bits k*SLICE .. k*SLICE+SLICE-1): per bit p=a^b, g=a&b, s=p^c, next c = g|(p&c), with c starting from the stored running carry.
REQ-017 The slice-k sum bits SHALL be written into the sum register at that edge; other bits SHALL hold.
REQ-018 The running carry SHALL start at the latched cin and update to the slice carry-out every RUN cycle.
REQ-019 After the edge processing slice WIDTH/SLICE-1, the FSM SHALL enter DONE and cout SHALL equal the final carry.
REQ-020 Latency SHALL be WIDTH/SLICE edges from the accepting edge to done=1; done SHALL be high for exactly one cycle unless a new start is accepted.
REQ-021 sum and cout SHALL hold their last values in IDLE until the next accepted start.
REQ-022 Arithmetic SHALL be unsigned modulo 2^WIDTH; carry beyond bit WIDTH-1 appears only on cout.
REQ-023 WIDTH SHALL be an integer multiple of SLICE; other values are unsupported.
REQ-024 sum bits not yet processed during RUN SHALL retain their previous values; sum is valid only when done=1 or later in IDLE.

Reset
REQ-025 With rst=1 at a rising edge, state SHALL become IDLE and sum, cout, the running carry, the slice index, busy and done SHALL become 0, regardless of state, including mid-RUN.
REQ-026 rst SHALL take priority over start on the same edge; an in-flight addition is discarded with no done pulse.

Configuration
REQ-027 With macro ADDER_SEQ_OVF_EN defined, the block SHALL add output port ovf, 1 bit, = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, registered with cout, reset to 0, held like sum.
REQ-028 Without ADDER_SEQ_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=32, SLICE=4)
REQ-029 Basic: a=0x0000_0001, b=0x0000_0002, cin=0, start one cycle -> busy 8 cycles, done pulses once 8 edges later, sum=0x0000_0003, cout=0.
REQ-030 Full carry ripple: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1; with ADDER_SEQ_OVF_EN, ovf=0.
REQ-031 Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001, cin=0 -> sum=0x8000_0000, cout=0, ovf=1 when enabled.
REQ-032 Start during RUN: second start with a=b=0xFFFF_FFFF mid-RUN -> ignored; first result delivered unchanged, only one done pulse.
REQ-033 Back-to-back: start held in DONE with a=5, b=6 -> new RUN begins immediately, done after 8 edges, sum=0x0000_000B; prior sum held during DONE cycle.
REQ-034 Reset mid-RUN: rst=1 at slice 3 -> next cycle state IDLE, sum=0, cout=0, busy=0, done never pulses for that operation.
